// File: rtl/contador_pkg.sv
// ============================================================================
// contador_pkg : next-state priority encoding shared by the counter family
// Revision 1.0
// ============================================================================
`default_nettype none

package contador_pkg;

  // Next-state action, listed from highest to lowest priority
  typedef enum logic [1:0] {
    ACC_CLR   = 2'd0,
    ACC_LOAD  = 2'd1,
    ACC_COUNT = 2'd2,
    ACC_HOLD  = 2'd3
  } accion_t;

  function automatic accion_t elegir_accion(input logic clr_n,
                                            input logic ld,
                                            input logic en);
    if (!clr_n)  return ACC_CLR;
    else if (ld) return ACC_LOAD;
    else if (en) return ACC_COUNT;
    else         return ACC_HOLD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ff_jk_sinc.sv
// ============================================================================
// ff_jk_sinc : JK flip-flop, falling edge, synchronous active-low clear
// Revision 1.0
// ============================================================================
`default_nettype none

module ff_jk_sinc (
  input  logic clk,
  input  logic clr_n_i,
  input  logic j_i,
  input  logic k_i,
  output logic q_o
);

  logic q_q;

  always_ff @(negedge clk) begin
    if (!clr_n_i) begin
      q_q <= 1'b0;
    end else begin
      case ({j_i, k_i})
        2'b01:   q_q <= 1'b0;
        2'b10:   q_q <= 1'b1;
        2'b11:   q_q <= ~q_q;
        default: q_q <= q_q;
      endcase
    end
  end

  assign q_o = q_q;

endmodule

`default_nettype wire

// File: rtl/contador_sinc_mod.sv
// ============================================================================
// contador_sinc_mod : modulo-N up/down counter with load, built from JK stages
// Revision 1.0
// ============================================================================
`default_nettype none

module contador_sinc_mod
  import contador_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int MODULO = 16
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             EN,
  input  logic             UP,
  input  logic             LD,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             TC,
  output logic             WRAP,
  output logic             LERR
);

  localparam logic [WIDTH-1:0] c_max  = WIDTH'(MODULO - 1);
  localparam logic [WIDTH-1:0] c_cero = '0;
  localparam logic [WIDTH-1:0] c_uno  = WIDTH'(1);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             wrap_q;
  logic             wrap_d;
  logic             lerr_q;
  logic             lerr_d;
  logic             w_d_valido;
  logic             w_en_max;
  logic             w_en_cero;
  accion_t          w_accion;

  assign w_accion   = elegir_accion(CLR, LD, EN);
  assign w_d_valido = (32'(D) < 32'(MODULO));
  assign w_en_max   = (q_q == c_max);
  assign w_en_cero  = (q_q == c_cero);

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    case (w_accion)
      ACC_CLR: q_d = c_cero;
      ACC_LOAD: begin
        // An out-of-range load leaves the count untouched and only flags it
        if (w_d_valido) q_d = D;
        else            lerr_d = 1'b1;
      end
      ACC_COUNT: begin
        if (UP) begin
          if (w_en_max) begin
            q_d    = c_cero;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q + c_uno;
          end
        end else begin
          if (w_en_cero) begin
            q_d    = c_max;
            wrap_d = 1'b1;
          end else begin
            q_d = q_q - c_uno;
          end
        end
      end
      ACC_HOLD: q_d = q_q;
    endcase
  end

  // J sets bits that must rise, K clears bits that must fall
  assign w_j = q_d & ~q_q;
  assign w_k = ~q_d & q_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bits
    ff_jk_sinc u_ff (
      .clk     (clk),
      .clr_n_i (CLR),
      .j_i     (w_j[i]),
      .k_i     (w_k[i]),
      .q_o     (q_q[i])
    );
  end

  always_ff @(negedge clk) begin
    if (!CLR) begin
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  assign Q    = q_q;
  assign TC   = EN & ((UP & w_en_max) | (~UP & w_en_cero));
  assign WRAP = wrap_q;
  assign LERR = lerr_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_sinc_mod.sv
// ============================================================================
// tb_contador_sinc_mod : self-checking bench for contador_sinc_mod
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_contador_sinc_mod;

  localparam int c_mod = 10;

  logic       clk;
  logic       CLR, EN, UP, LD;
  logic [3:0] D, Q;
  logic       TC, WRAP, LERR;

  logic       d_CLR, d_EN;
  logic [3:0] d_Q;
  logic       d_TC, d_WRAP, d_LERR;

  logic       c_CLR, c_EN;
  logic [3:0] lo_Q, hi_Q;
  logic       lo_TC, lo_WRAP, lo_LERR, hi_TC, hi_WRAP, hi_LERR;

  int compared;
  int mismatched;

  int m_q;
  bit m_wrap, m_lerr;

  contador_sinc_mod #(.WIDTH(4), .MODULO(c_mod)) dut (
    .clk(clk), .CLR(CLR), .EN(EN), .UP(UP), .LD(LD), .D(D),
    .Q(Q), .TC(TC), .WRAP(WRAP), .LERR(LERR)
  );

  contador_sinc_mod dut_def (
    .clk(clk), .CLR(d_CLR), .EN(d_EN), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .Q(d_Q), .TC(d_TC), .WRAP(d_WRAP), .LERR(d_LERR)
  );

  contador_sinc_mod #(.WIDTH(4), .MODULO(c_mod)) u_lo (
    .clk(clk), .CLR(c_CLR), .EN(c_EN), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .Q(lo_Q), .TC(lo_TC), .WRAP(lo_WRAP), .LERR(lo_LERR)
  );

  contador_sinc_mod #(.WIDTH(4), .MODULO(c_mod)) u_hi (
    .clk(clk), .CLR(c_CLR), .EN(lo_TC), .UP(1'b1), .LD(1'b0), .D(4'd0),
    .Q(hi_Q), .TC(hi_TC), .WRAP(hi_WRAP), .LERR(hi_LERR)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  // Spec-level model of one falling edge: priority CLR, LD, EN, hold
  task automatic model_edge(input bit clr, input bit ld, input bit en, input bit up,
                            input int d, input int modv,
                            inout int q, output bit w, output bit le);
    w  = 1'b0;
    le = 1'b0;
    if (!clr)                    q = 0;
    else if (ld) begin
      if (d < modv)              q = d;
      else                       le = 1'b1;
    end else if (en) begin
      if (up) begin w = (q == modv - 1); q = (q + 1) % modv;        end
      else    begin w = (q == 0);        q = (q + modv - 1) % modv; end
    end
  endtask

  function automatic bit model_tc(input bit en, input bit up, input int q, input int modv);
    return en && ((up && q == modv - 1) || (!up && q == 0));
  endfunction

  task automatic edge_main();
    model_edge(CLR, LD, EN, UP, int'(D), c_mod, m_q, m_wrap, m_lerr);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    CLR = 1'b0; LD = 1'b1; D = 4'd5; EN = 1'b1; UP = 1'b0;
    edge_main();
    compared++;
    if (Q !== 4'd0) begin mismatched++; $display("FAIL reset_q: got %0d want 0", Q); end
    compared++;
    if (WRAP !== 1'b0 || LERR !== 1'b0) begin
      mismatched++; $display("FAIL reset_flags: got wrap=%b lerr=%b want 0 0", WRAP, LERR);
    end
    compared++;
    if (TC !== 1'b1) begin mismatched++; $display("FAIL reset_tc: got %b want 1", TC); end
  endtask

  task automatic test_up_wrap();
    CLR = 1'b1; LD = 1'b0; EN = 1'b1; UP = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1;
      compared++;
      if (TC !== (i == 9)) begin mismatched++; $display("FAIL up_tc[%0d]: got %b want %b", i, TC, i == 9); end
      edge_main();
      compared++;
      if (Q !== 4'((i + 1) % 10) || WRAP !== (i == 9)) begin
        mismatched++;
        $display("FAIL up_step[%0d]: got q=%0d wrap=%b want q=%0d wrap=%b", i, Q, WRAP, (i + 1) % 10, i == 9);
      end
    end
  endtask

  task automatic test_down_wrap();
    LD = 1'b1; D = 4'd1; EN = 1'b1; UP = 1'b0;
    edge_main();
    compared++;
    if (Q !== 4'd1) begin mismatched++; $display("FAIL down_load: got %0d want 1", Q); end
    LD = 1'b0;
    #1;
    compared++;
    if (TC !== 1'b0) begin mismatched++; $display("FAIL down_tc1: got %b want 0", TC); end
    edge_main();
    compared++;
    if (Q !== 4'd0 || WRAP !== 1'b0 || TC !== 1'b1) begin
      mismatched++; $display("FAIL down_to0: got q=%0d wrap=%b tc=%b want 0 0 1", Q, WRAP, TC);
    end
    edge_main();
    compared++;
    if (Q !== 4'd9 || WRAP !== 1'b1 || TC !== 1'b0) begin
      mismatched++; $display("FAIL down_to9: got q=%0d wrap=%b tc=%b want 9 1 0", Q, WRAP, TC);
    end
    edge_main();
    compared++;
    if (Q !== 4'd8 || WRAP !== 1'b0) begin
      mismatched++; $display("FAIL down_to8: got q=%0d wrap=%b want 8 0", Q, WRAP);
    end
  endtask

  task automatic test_load();
    LD = 1'b1; EN = 1'b1; UP = 1'b1; D = 4'd7;
    edge_main();
    compared++;
    if (Q !== 4'd7 || LERR !== 1'b0 || WRAP !== 1'b0) begin
      mismatched++; $display("FAIL load_ok: got q=%0d lerr=%b wrap=%b want 7 0 0", Q, LERR, WRAP);
    end
    D = 4'd12;
    edge_main();
    compared++;
    if (Q !== 4'd7 || LERR !== 1'b1) begin
      mismatched++; $display("FAIL load_err: got q=%0d lerr=%b want 7 1", Q, LERR);
    end
    LD = 1'b0; EN = 1'b0;
    edge_main();
    compared++;
    if (Q !== 4'd7 || LERR !== 1'b0) begin
      mismatched++; $display("FAIL load_hold: got q=%0d lerr=%b want 7 0", Q, LERR);
    end
  endtask

  task automatic test_cascade();
    c_CLR = 1'b0; c_EN = 1'b0;
    @(negedge clk); #1;
    c_CLR = 1'b1; c_EN = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      @(negedge clk); #1;
      if (i == 10) begin
        compared++;
        if (hi_Q !== 4'd1 || lo_Q !== 4'd0) begin
          mismatched++; $display("FAIL cascade_10: got hi=%0d lo=%0d want 1 0", hi_Q, lo_Q);
        end
      end
    end
    compared++;
    if (hi_Q !== 4'd2 || lo_Q !== 4'd5) begin
      mismatched++; $display("FAIL cascade_25: got hi=%0d lo=%0d want 2 5", hi_Q, lo_Q);
    end
    compared++;
    if ({hi_TC, hi_WRAP, hi_LERR, lo_WRAP, lo_LERR} !== 5'b0) begin
      mismatched++;
      $display("FAIL cascade_flags: got %b want 00000", {hi_TC, hi_WRAP, hi_LERR, lo_WRAP, lo_LERR});
    end
    c_EN = 1'b0;
  endtask

  task automatic test_default();
    int wraps;
    wraps = 0;
    d_CLR = 1'b0; d_EN = 1'b0;
    @(negedge clk); #1;
    d_CLR = 1'b1; d_EN = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk); #1;
      if (d_WRAP === 1'b1) wraps++;
    end
    compared++;
    if (d_Q !== 4'd0 || wraps != 1 || d_WRAP !== 1'b1) begin
      mismatched++; $display("FAIL default_16: got q=%0d wraps=%0d last=%b want 0 1 1", d_Q, wraps, d_WRAP);
    end
    compared++;
    if (d_TC !== 1'b0 || d_LERR !== 1'b0) begin
      mismatched++; $display("FAIL default_flags: got tc=%b lerr=%b want 0 0", d_TC, d_LERR);
    end
    d_EN = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      CLR = ($urandom_range(0, 19) != 0);
      LD  = ($urandom_range(0, 4) == 0);
      EN  = ($urandom_range(0, 3) != 0);
      UP  = 1'($urandom_range(0, 1));
      D   = 4'($urandom_range(0, 15));
      #1;
      compared++;
      if (TC !== model_tc(EN, UP, m_q, c_mod)) begin
        mismatched++; $display("FAIL rand_tc[%0d]: got %b want %b", i, TC, model_tc(EN, UP, m_q, c_mod));
      end
      edge_main();
      compared++;
      if (Q !== 4'(m_q) || WRAP !== m_wrap || LERR !== m_lerr) begin
        mismatched++;
        $display("FAIL rand_step[%0d]: got q=%0d wrap=%b lerr=%b want q=%0d wrap=%b lerr=%b",
                 i, Q, WRAP, LERR, m_q, m_wrap, m_lerr);
      end
    end
  endtask

  initial begin
    compared = 0; mismatched = 0; m_q = 0; m_wrap = 0; m_lerr = 0;
    CLR = 1'b0; EN = 1'b0; UP = 1'b1; LD = 1'b0; D = 4'd0;
    d_CLR = 1'b0; d_EN = 1'b0; c_CLR = 1'b0; c_EN = 1'b0;
    #1;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_cascade();
    test_default();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/contador_sinc_mod.md
CONTADOR_SINC_MOD -- requirements
Module: contador_sinc_mod

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (1..16).
REQ-002 SHALL have parameter MODULO, default 16, count modulus (2..2**WIDTH); the count sequence is 0..MODULO-1.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its falling edge.
REQ-004 SHALL have port CLR  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port EN  input  1  count enable, active-high.
REQ-006 SHALL have port UP  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port LD  input  1  synchronous parallel load, active-high.
REQ-008 SHALL have port D  input  WIDTH  parallel load value.
REQ-009 SHALL have port Q  output  WIDTH  registered count.
REQ-010 SHALL have port TC  output  1  terminal count, combinational.
REQ-011 SHALL have port WRAP  output  1  registered one-cycle wrap pulse.
REQ-012 SHALL have port LERR  output  1  registered one-cycle load-error pulse.

Function
REQ-013 SHALL evaluate, at each falling clk edge, in priority order: CLR=0, then LD=1, then EN=1, else hold.
REQ-014 SHALL, with LD=1 and D < MODULO, set Q = D; WRAP = 0; LERR = 0.
REQ-015 SHALL, with LD=1 and D >= MODULO, hold Q, set LERR = 1 for one cycle; WRAP = 0.
REQ-016 SHALL, with LD=0, EN=1, UP=1, set Q = Q+1, or 0 when Q = MODULO-1 (wrap).
REQ-017 SHALL, with LD=0, EN=1, UP=0, set Q = Q-1, or MODULO-1 when Q = 0 (wrap).
REQ-018 SHALL set WRAP = 1 on the edge following a wrap per REQ-016/017, otherwise 0.
REQ-019 SHALL, with LD=0 and EN=0, hold Q; WRAP = 0; LERR = 0.
REQ-020 SHALL drive TC = EN & ((UP & Q==MODULO-1) | (~UP & Q==0)), allowing cascading of stages (TC of one into EN of the next).
REQ-021 SHALL allow UP to change on any cycle; the new direction applies from the next falling edge, no extra latency.
REQ-022 SHALL perform all arithmetic modulo MODULO in WIDTH bits; no intermediate value outside 0..MODULO-1 ever appears on Q.
REQ-023 SHALL never produce X on any output after the first reset edge, for any input combination.

Reset
REQ-024 SHALL, on a falling clk edge with CLR=0, set Q = 0, WRAP = 0, LERR = 0, regardless of LD, EN, UP, D.
REQ-025 SHALL treat CLR=0 asserted mid-count or concurrently with LD=1 identically to REQ-024 (reset wins).
REQ-026 SHALL leave TC combinationally valid during reset (e.g. UP=0, EN=1 gives TC=1 once Q=0).

Structure
REQ-027 SHALL place the encoded next-state priority (CLR/LD/EN/hold) as named constants in a shared package contador_pkg, for reuse by future counters.
REQ-028 SHALL build the count register from WIDTH instances of one sub-module ff_jk_sinc (JK flip-flop, falling edge, synchronous active-low clear), with J/K next-state logic in the parent.
REQ-029 SHALL keep TC purely combinational and WRAP/LERR as plain registers in the parent.

Verification (WIDTH=4, MODULO=10 unless stated)
REQ-030 SHALL verify reset: CLR=0 one edge with LD=1, D=5 -> Q=0, WRAP=0, LERR=0.
REQ-031 SHALL verify up-count wrap: EN=1, UP=1 from Q=0, 10 edges -> Q runs 1..9,0; WRAP=1 only after the 9->0 edge; TC=1 only while Q=9.
REQ-032 SHALL verify down-count wrap: load D=1, EN=1, UP=0 -> Q=0 then 9; TC=1 while Q=0; WRAP pulses after 0->9.
REQ-033 SHALL verify load priority and error: LD=1, EN=1, D=7 -> Q=7; then LD=1, D=12 -> Q stays 7, LERR=1 one cycle.
REQ-034 SHALL verify cascade: two instances, TC of first into EN of second, 25 up edges from 0 -> Q_hi=2, Q_lo=5.
REQ-035 SHALL verify default parameters (WIDTH=4, MODULO=16): 16 up edges from 0 -> Q=0 with one WRAP pulse.
